// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl: in-order data-memory request tracker; define DMEM_REQ_MISALIGN_CHK_EN to trap misaligned H/W accesses
package ooop_types;
  typedef enum logic [1:0] {LS_B = 2'd0, LS_H = 2'd1, LS_W = 2'd2} ls_size_t;
endpackage

module dmem_req_ctrl
  import ooop_types::*;
#(
  parameter int TAG_W = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  input  ls_size_t         req_size_i,
  input  logic             req_unsigned_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output ls_size_t         mem_size_o,
  input  logic             mem_rvalid_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic [31:0]      resp_data_o,
  output logic             resp_is_store_o,
  output logic             resp_err_o,
  output logic             spurious_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
`ifdef DMEM_REQ_MISALIGN_CHK_EN
  localparam bit MIS_CHK = 1'b1;
`else
  localparam bit MIS_CHK = 1'b0;
`endif
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic             we_q   [DEPTH];
  ls_size_t         size_q [DEPTH];
  logic [1:0]       off_q  [DEPTH];
  logic             uns_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] pend_q, done_q, err_q;
  logic [PW-1:0]    head_q, tail_q, cpl_idx;
  logic [CW-1:0]    count_q;
  logic             accept, mis, pop, cpl_hit, cpl;
  logic [7:0]       rb;
  logic [15:0]      rh;
  logic [31:0]      fmt;
  assign req_ready_o = count_q < CW'(DEPTH);
  assign mis = MIS_CHK && ((req_size_i == LS_H && req_addr_i[0]) ||
                           (req_size_i == LS_W && req_addr_i[1:0] != 2'b00));
  assign accept = req_valid_i & req_ready_o & ~rst;
  assign mem_en_o = accept & ~mis;
  assign mem_we_o = req_we_i;
  assign mem_addr_o = req_addr_i;
  assign mem_wdata_o = req_wdata_i;
  assign mem_size_o = req_size_i;
  assign resp_valid_o = done_q[head_q];
  assign pop = resp_valid_o & resp_ready_i;
  assign resp_tag_o = resp_valid_o ? tag_q[head_q] : '0;
  assign resp_data_o = resp_valid_o ? data_q[head_q] : '0;
  assign resp_is_store_o = resp_valid_o & we_q[head_q];
  assign resp_err_o = resp_valid_o & err_q[head_q];
  assign cpl = mem_rvalid_i & cpl_hit;
  // Locate the oldest entry still waiting on memory, scanning from head
  always_comb begin
    cpl_hit = 1'b0;
    cpl_idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (!cpl_hit && pend_q[head_q + PW'(i)]) begin
        cpl_hit = 1'b1;
        cpl_idx = head_q + PW'(i);
      end
    end
  end
  assign rb = mem_rdata_i[{off_q[cpl_idx], 3'b000} +: 8];
  assign rh = mem_rdata_i[{off_q[cpl_idx][1], 4'b0000} +: 16];
  // Extract and extend load data for the completing entry; stores record zero
  always_comb begin
    fmt = we_q[cpl_idx] ? '0 :
          size_q[cpl_idx] == LS_B ? {{24{~uns_q[cpl_idx] & rb[7]}}, rb} :
          size_q[cpl_idx] == LS_H ? {{16{~uns_q[cpl_idx] & rh[15]}}, rh} : mem_rdata_i;
  end
  // Control state: pointers, occupancy, per-entry pend/done and sticky spurious flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      pend_q <= '0;
      done_q <= '0;
      spurious_o <= 1'b0;
    end else begin
      if (accept) begin
        tail_q <= tail_q + 1'b1;
        pend_q[tail_q] <= ~mis;
        done_q[tail_q] <= mis;
      end
      if (cpl) begin
        pend_q[cpl_idx] <= 1'b0;
        done_q[cpl_idx] <= 1'b1;
      end
      if (pop) begin
        done_q[head_q] <= 1'b0;
        head_q <= head_q + 1'b1;
      end
      count_q <= count_q + CW'(accept) - CW'(pop);
      if (mem_rvalid_i & ~cpl_hit) spurious_o <= 1'b1;
    end
  end
  // Entry payload, only meaningful while the matching pend/done bit is set
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q[tail_q] <= req_tag_i;
      we_q[tail_q] <= req_we_i;
      size_q[tail_q] <= req_size_i;
      off_q[tail_q] <= req_addr_i[1:0];
      uns_q[tail_q] <= req_unsigned_i;
      err_q[tail_q] <= mis;
      data_q[tail_q] <= '0;
    end
    if (cpl) data_q[cpl_idx] <= fmt;
  end
endmodule

// File: tb/tb_dmem_req_ctrl.sv
// tb_dmem_req_ctrl: directed bench for dmem_req_ctrl with a fixed 2-cycle memory model
module tb_dmem_req_ctrl;
  import ooop_types::*;
`ifdef DMEM_REQ_MISALIGN_CHK_EN
  localparam bit EXP_MIS = 1'b1;
`else
  localparam bit EXP_MIS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid, req_ready, req_we, req_uns;
  logic [31:0] req_addr, req_wdata;
  ls_size_t req_size;
  logic [5:0] req_tag;
  logic mem_en, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  ls_size_t mem_size;
  logic resp_valid, resp_ready, resp_is_store, resp_err, spurious;
  logic [5:0] resp_tag;
  logic [31:0] resp_data;
  logic [31:0] rdata_src = 32'h0;
  logic s1 = 1'b0, s2 = 1'b0;
  logic [31:0] d1 = 32'h0, d2 = 32'h0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    s1 <= mem_en;
    s2 <= s1;
    d1 <= rdata_src;
    d2 <= d1;
  end
  assign mem_rvalid = s2;
  assign mem_rdata = d2;

  dmem_req_ctrl #(.TAG_W(6), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_unsigned_i(req_uns), .req_tag_i(req_tag),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_size_o(mem_size),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_tag_o(resp_tag), .resp_data_o(resp_data),
    .resp_is_store_o(resp_is_store), .resp_err_o(resp_err), .spurious_o(spurious)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input ls_size_t sz, input logic uns, input logic [5:0] tag,
                       input logic [31:0] rd);
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wdata;
    req_size = sz;
    req_uns = uns;
    req_tag = tag;
    rdata_src = rd;
    #1;
  endtask

  task automatic resp(input string name, input logic [5:0] tag, input logic [31:0] data);
    chk({name, "_valid"}, 32'(resp_valid), 32'd1);
    chk({name, "_tag"}, 32'(resp_tag), 32'(tag));
    chk({name, "_data"}, resp_data, data);
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = LS_W; req_uns = 1'b0; req_tag = '0; resp_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_spur", 32'(spurious), 32'd0);
    chk("rst_tag", 32'(resp_tag), 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    tick; tick;
    rst = 1'b0;
    tick;
    // aligned word load, 2-cycle memory latency
    issue(1'b0, 32'h10, 32'h0, LS_W, 1'b0, 6'd5, 32'hDEADBEEF);
    chk("w_mem_en", 32'(mem_en), 32'd1);
    chk("w_mem_addr", mem_addr, 32'h10);
    chk("w_mem_we", 32'(mem_we), 32'd0);
    chk("w_mem_size", 32'(mem_size), 32'(LS_W));
    tick;
    req_valid = 1'b0;
    #1;
    chk("w_idle_en", 32'(mem_en), 32'd0);
    chk("w_c1", 32'(resp_valid), 32'd0);
    tick;
    chk("w_c2", 32'(resp_valid), 32'd0);
    tick;
    resp("w_resp", 6'd5, 32'hDEADBEEF);
    chk("w_store", 32'(resp_is_store), 32'd0);
    tick;
    chk("w_pop", 32'(resp_valid), 32'd0);
    // byte / half formatting
    issue(1'b0, 32'h13, 32'h0, LS_B, 1'b0, 6'd1, 32'h80FF1234); tick;
    issue(1'b0, 32'h13, 32'h0, LS_B, 1'b1, 6'd2, 32'h80FF1234); tick;
    issue(1'b0, 32'h12, 32'h0, LS_H, 1'b0, 6'd3, 32'h80FF1234); tick;
    req_valid = 1'b0;
    resp("fmt_bs", 6'd1, 32'hFFFFFF80);
    tick;
    resp("fmt_bu", 6'd2, 32'h00000080);
    tick;
    resp("fmt_hs", 6'd3, 32'hFFFF80FF);
    tick;
    chk("fmt_empty", 32'(resp_valid), 32'd0);
    // fill to DEPTH with responses stalled
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 32'h40 + 32'(4 * i), 32'h0, LS_W, 1'b0, 6'(10 + i), 32'h100 + 32'(i));
      chk("full_rdy_pre", 32'(req_ready), 32'd1);
      tick;
    end
    issue(1'b0, 32'h50, 32'h0, LS_W, 1'b0, 6'd14, 32'h5555);
    chk("full_rdy", 32'(req_ready), 32'd0);
    chk("full_held", 32'(mem_en), 32'd0);
    tick;
    chk("full_rdy2", 32'(req_ready), 32'd0);
    chk("full_held2", 32'(mem_en), 32'd0);
    resp("full_stall", 6'd10, 32'h100);
    tick;
    resp_ready = 1'b1;
    #1;
    resp("full_h10", 6'd10, 32'h100);
    tick;
    chk("full_rdy_pop", 32'(req_ready), 32'd1);
    chk("full_5th_en", 32'(mem_en), 32'd1);
    chk("full_5th_addr", mem_addr, 32'h50);
    resp("full_t11", 6'd11, 32'h101);
    tick;
    req_valid = 1'b0;
    resp("full_t12", 6'd12, 32'h102);
    tick;
    resp("full_t13", 6'd13, 32'h103);
    tick;
    resp("full_t14", 6'd14, 32'h5555);
    tick;
    chk("full_empty", 32'(resp_valid), 32'd0);
    // byte store
    issue(1'b1, 32'h21, 32'hAB, LS_B, 1'b0, 6'd7, 32'h12345678);
    chk("st_en", 32'(mem_en), 32'd1);
    chk("st_we", 32'(mem_we), 32'd1);
    chk("st_wdata", mem_wdata, 32'hAB);
    chk("st_addr", mem_addr, 32'h21);
    chk("st_size", 32'(mem_size), 32'(LS_B));
    tick;
    req_valid = 1'b0;
    tick; tick;
    resp("st_resp", 6'd7, 32'h0);
    chk("st_is_store", 32'(resp_is_store), 32'd1);
    tick;
    chk("st_empty", 32'(resp_valid), 32'd0);
    // misaligned word between two aligned loads
    issue(1'b0, 32'h20, 32'h0, LS_W, 1'b0, 6'd20, 32'h11111111);
    chk("mis_en0", 32'(mem_en), 32'd1);
    tick;
    issue(1'b0, 32'h22, 32'h0, LS_W, 1'b0, 6'd21, 32'h22222222);
    chk("mis_en1", 32'(mem_en), EXP_MIS ? 32'd0 : 32'd1);
    tick;
    issue(1'b0, 32'h24, 32'h0, LS_W, 1'b0, 6'd22, 32'h33333333);
    chk("mis_en2", 32'(mem_en), 32'd1);
    tick;
    req_valid = 1'b0;
    resp("mis_r0", 6'd20, 32'h11111111);
    chk("mis_err0", 32'(resp_err), 32'd0);
    tick;
    resp("mis_r1", 6'd21, EXP_MIS ? 32'h0 : 32'h22222222);
    chk("mis_err1", 32'(resp_err), 32'(EXP_MIS));
    tick;
    resp("mis_r2", 6'd22, 32'h33333333);
    chk("mis_err2", 32'(resp_err), 32'd0);
    tick;
    chk("mis_empty", 32'(resp_valid), 32'd0);
    // reset with two loads in flight
    issue(1'b0, 32'h60, 32'h0, LS_W, 1'b0, 6'd30, 32'hAAAA); tick;
    issue(1'b0, 32'h64, 32'h0, LS_W, 1'b0, 6'd31, 32'hBBBB); tick;
    rst = 1'b1;
    #1;
    chk("rr_ready", 32'(req_ready), 32'd1);
    chk("rr_rvalid", 32'(resp_valid), 32'd0);
    chk("rr_mem_en", 32'(mem_en), 32'd0);
    chk("rr_spur", 32'(spurious), 32'd0);
    chk("rr_tag", 32'(resp_tag), 32'd0);
    chk("rr_data", resp_data, 32'd0);
    req_valid = 1'b0;
    #1 rst = 1'b0;
    tick;
    chk("rr_spur1", 32'(spurious), 32'd1);
    chk("rr_late1", 32'(resp_valid), 32'd0);
    tick;
    chk("rr_spur2", 32'(spurious), 32'd1);
    chk("rr_late2", 32'(resp_valid), 32'd0);
    issue(1'b0, 32'h70, 32'h0, LS_W, 1'b0, 6'd33, 32'hCAFEF00D);
    chk("rr_new_en", 32'(mem_en), 32'd1);
    tick;
    req_valid = 1'b0;
    tick; tick;
    resp("rr_new", 6'd33, 32'hCAFEF00D);
    chk("rr_spur3", 32'(spurious), 32'd1);
    tick;
    chk("rr_empty", 32'(resp_valid), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_req_ctrl.md
DMEM_REQ_CTRL -- requirements
Module: dmem_req_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 6, width of the load/store tag.
REQ-002 SHALL have parameter DEPTH, default 4, power of two ≥2, max entries allocated.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid_i  in  1  core request valid.
REQ-006 req_ready_o  out  1  request accepted this cycle when high with req_valid_i.
REQ-007 req_we_i  in  1  1 = store, 0 = load.
REQ-008 req_addr_i  in  32  byte address.
REQ-009 req_wdata_i  in  32  store data, LSB-aligned.
REQ-010 req_size_i  in  ooop_types::ls_size_t  LS_B/LS_H/LS_W.
REQ-011 req_unsigned_i  in  1  load zero-extend when high, else sign-extend.
REQ-012 req_tag_i  in  TAG_W  request tag.
REQ-013 mem_en_o / mem_we_o  out  1/1  memory request strobe / write.
REQ-014 mem_addr_o / mem_wdata_o  out  32/32  memory address / data.
REQ-015 mem_size_o  out  ls_size_t  memory access size.
REQ-016 mem_rvalid_i / mem_rdata_i  in  1/32  memory response, exactly 2 cycles after mem_en_o, no backpressure.
REQ-017 resp_valid_o / resp_ready_i  out/in  1/1  completion handshake.
REQ-018 resp_tag_o / resp_data_o  out  TAG_W/32  completion tag, formatted load data (0 for stores).
REQ-019 resp_is_store_o / resp_err_o  out  1/1  completion is store / misaligned error.
REQ-020 spurious_o  out  1  sticky: mem_rvalid_i with no pending entry.

Function
REQ-021 Circular buffer of DEPTH entries {tag, we, size, off[1:0], unsigned, pend, done, err, data}; count = allocated entries.
REQ-022 req_ready_o = (count < DEPTH), from registered state only; no same-cycle pop bypass.
REQ-023 Accept (req_valid_i & req_ready_o) allocates the tail entry and, same cycle combinationally, drives mem_en_o=1 with we/addr/wdata/size passed through; entry pend=1, done=0.
REQ-024 mem_en_o SHALL be 0 in every cycle without an accept.
REQ-025 mem_rvalid_i completes the oldest entry with pend=1: pend<=0, done<=1, data<=formatted result.
REQ-026 Load formatting: LS_B selects byte off, LS_H selects half off[1], LS_W whole word; extend to 32 bits per unsigned bit; stores record data 0.
REQ-027 resp_valid_o = head.done; head pops on resp_valid_o & resp_ready_i; outputs held stable while stalled.
REQ-028 Accept and pop in same cycle: count unchanged; completion and pop of different entries same cycle both take effect.
REQ-029 Completions SHALL be returned in acceptance order.
REQ-030 mem_rvalid_i with no pend entry: response dropped, spurious_o<=1 until reset.
REQ-031 Pointers wrap modulo DEPTH; full (count=DEPTH) and empty (count=0) distinguished by count.

Reset
REQ-032 rst high: count, pointers, all pend/done bits, spurious_o cleared immediately; req_ready_o=1, resp_valid_o=0, mem_en_o=0, resp_* data/tag/err 0.
REQ-033 In-flight memory responses arriving after reset release SHALL be handled per REQ-030.

Configuration
REQ-034 Macro DMEM_REQ_MISALIGN_CHK_EN.
REQ-035 Defined: LS_H with addr[0]=1 or LS_W with addr[1:0]≠0 is accepted but not issued (mem_en_o=0); entry allocated with pend=0, done=1, err=1, data=0; order preserved.
REQ-036 Undefined: all accepted requests issued unchanged; resp_err_o tied 0.

Verification
REQ-037 Reset, then load LS_W addr 0x10, mem_rdata 0xDEADBEEF at cycle+2 -> resp_valid_o cycle+3, resp_data_o 0xDEADBEEF, tag echoed.
REQ-038 Load LS_B addr 0x13 signed, rdata 0x80FF_1234 -> resp_data_o 0xFFFFFF80; same unsigned -> 0x00000080; LS_H addr 0x12 signed -> 0xFFFF80FF.
REQ-039 resp_ready_i=0, issue 4 back-to-back loads -> req_ready_o drops after 4th; 5th held; raise resp_ready_i -> tags returned in order, 5th issued after first pop.
REQ-040 Store LS_B addr 0x21 data 0xAB -> mem_en_o/mem_we_o=1 same cycle, resp_is_store_o=1, resp_data_o 0 after 2-cycle response.
REQ-041 With macro: load LS_W addr 0x22 between two aligned loads -> no mem_en_o for it, resp_err_o=1 on 2nd completion, order kept.
REQ-042 Assert rst with 2 loads in flight -> outputs cleared; both late rvalids set spurious_o=1; next load completes normally.
